// File: rtl/bcd_digit_entry_if.sv
// Digit-entry bus: keypad-side digit handshake plus committed-result outputs.
interface bcd_digit_entry_if #(
   parameter int unsigned COUNTWIDTH = 6,
   parameter int unsigned MAXDIGITS  = 2
);
   localparam int unsigned CNTW = $clog2(MAXDIGITS + 1);

   logic [3:0]            digit_in;
   logic                  digit_valid;
   logic                  digit_ready;
   logic                  enter;
   logic                  clear;
   logic [COUNTWIDTH-1:0] value;
   logic                  done;
   logic                  overflow;
   logic                  bad_digit;
   logic [CNTW-1:0]       digit_count;

   // Digit source / result consumer side
   modport master (
      output digit_in, digit_valid, enter, clear,
      input  digit_ready, value, done, overflow, bad_digit, digit_count
   );

   // Accumulator block side
   modport slave (
      input  digit_in, digit_valid, enter, clear,
      output digit_ready, value, done, overflow, bad_digit, digit_count
   );
endinterface

// File: rtl/bcd_digit_entry.sv
// Accumulates BCD digits (MSD first) into a saturating COUNTWIDTH-bit binary
// value and commits it on an enter strobe.
// Optional: define DIGIT_ECHO_EN to add echo_seg, a 7-segment (active-low)
// echo of the last accepted valid digit.

`ifdef DIGIT_ECHO_EN
// Hex digit to active-low segments {g,f,e,d,c,b,a}.
module sevenseg (
   input  logic [3:0] i_digit,
   output logic [6:0] o_seg_n_c
);
   // Combinational segment lookup
   always_comb begin
      o_seg_n_c = 7'b1111111;
      case (i_digit)
         4'h0: o_seg_n_c = 7'b1000000;
         4'h1: o_seg_n_c = 7'b1111001;
         4'h2: o_seg_n_c = 7'b0100100;
         4'h3: o_seg_n_c = 7'b0110000;
         4'h4: o_seg_n_c = 7'b0011001;
         4'h5: o_seg_n_c = 7'b0010010;
         4'h6: o_seg_n_c = 7'b0000010;
         4'h7: o_seg_n_c = 7'b1111000;
         4'h8: o_seg_n_c = 7'b0000000;
         4'h9: o_seg_n_c = 7'b0010000;
         4'hA: o_seg_n_c = 7'b0001000;
         4'hB: o_seg_n_c = 7'b0000011;
         4'hC: o_seg_n_c = 7'b1000110;
         4'hD: o_seg_n_c = 7'b0100001;
         4'hE: o_seg_n_c = 7'b0000110;
         default: o_seg_n_c = 7'b0001110;
      endcase
   end
endmodule
`endif

module bcd_digit_entry #(
   parameter int unsigned COUNTWIDTH = 6,
   parameter int unsigned MAXDIGITS  = 2
) (
   input  logic              clock,
   input  logic              n_reset,
   bcd_digit_entry_if.slave  bus
`ifdef DIGIT_ECHO_EN
   ,
   output logic [6:0]        echo_seg
`endif
);
   localparam int unsigned CNTW = $clog2(MAXDIGITS + 1);
   localparam int unsigned EW   = COUNTWIDTH + 4;
   localparam logic [EW-1:0] MAXV = EW'({COUNTWIDTH{1'b1}});

   typedef enum logic [1:0] {IDLE, ENTRY, FULL} state_t;

   state_t                r_state;
   state_t                w_state_d;
   logic [COUNTWIDTH-1:0] r_acc, w_acc_next, w_acc_d;
   logic [CNTW-1:0]       r_count, w_count_next, w_count_d, w_count_inc;
   logic                  r_ovf, w_ovf_next, w_ovf_d;
   logic                  r_bad, w_bad_next, w_bad_d;
   logic [COUNTWIDTH-1:0] r_value;
   logic                  r_done, r_overflow, r_bad_digit;
   logic                  w_ready, w_accept, w_digit_ok, w_commit, w_flush;
   logic [EW-1:0]         w_prod;

   assign w_ready     = (r_state != FULL) && !bus.clear;
   assign w_accept    = bus.digit_valid && w_ready;
   assign w_digit_ok  = (bus.digit_in <= 4'd9);
   assign w_commit    = bus.enter && !bus.clear;
   assign w_flush     = bus.clear || bus.enter;
   assign w_prod      = EW'(r_acc) * EW'(10) + EW'(bus.digit_in);
   assign w_count_inc = r_count + CNTW'(1);

   // Next entry contents including any digit accepted this cycle, then register D-values
   always_comb begin
      w_state_d    = r_state;
      w_acc_next   = r_acc;
      w_count_next = r_count;
      w_ovf_next   = r_ovf;
      w_bad_next   = r_bad;
      if (w_accept) begin
         if (w_digit_ok) begin
            if (w_prod > MAXV) begin
               w_acc_next = {COUNTWIDTH{1'b1}};
               w_ovf_next = 1'b1;
            end else begin
               w_acc_next = COUNTWIDTH'(w_prod);
            end
            w_count_next = w_count_inc;
            w_state_d    = (w_count_inc == CNTW'(MAXDIGITS)) ? FULL : ENTRY;
         end else begin
            w_bad_next = 1'b1;
         end
      end
      w_acc_d   = w_acc_next;
      w_count_d = w_count_next;
      w_ovf_d   = w_ovf_next;
      w_bad_d   = w_bad_next;
      if (w_flush) begin
         w_state_d = IDLE;
         w_acc_d   = '0;
         w_count_d = '0;
         w_ovf_d   = 1'b0;
         w_bad_d   = 1'b0;
      end
   end

   // State and in-progress entry registers
   always_ff @(posedge clock) begin
      if (!n_reset) begin
         r_state <= IDLE;
         r_acc   <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
         r_bad   <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_acc   <= w_acc_d;
         r_count <= w_count_d;
         r_ovf   <= w_ovf_d;
         r_bad   <= w_bad_d;
      end
   end

   // Committed result, held between commits
   always_ff @(posedge clock) begin
      if (!n_reset) begin
         r_value     <= '0;
         r_done      <= 1'b0;
         r_overflow  <= 1'b0;
         r_bad_digit <= 1'b0;
      end else begin
         r_done <= w_commit;
         if (w_commit) begin
            r_value     <= w_acc_next;
            r_overflow  <= w_ovf_next;
            r_bad_digit <= w_bad_next;
         end
      end
   end

   assign bus.digit_ready = w_ready;
   assign bus.value       = r_value;
   assign bus.done        = r_done;
   assign bus.overflow    = r_overflow;
   assign bus.bad_digit   = r_bad_digit;
   assign bus.digit_count = r_count;

`ifdef DIGIT_ECHO_EN
   logic [3:0] r_echo;

   // Last accepted valid digit; dropped back to 0 when an entry ends
   always_ff @(posedge clock) begin
      if (!n_reset) begin
         r_echo <= 4'd0;
      end else if (w_flush) begin
         r_echo <= 4'd0;
      end else if (w_accept && w_digit_ok) begin
         r_echo <= bus.digit_in;
      end
   end

   sevenseg u_echo (
      .i_digit   (r_echo),
      .o_seg_n_c (echo_seg)
   );
`endif
endmodule

// File: tb/tb_bcd_digit_entry.sv
// Directed table-driven bench for bcd_digit_entry (COUNTWIDTH=6, MAXDIGITS=2).
module tb_bcd_digit_entry;
   localparam int unsigned CW = 6;
   localparam int unsigned MD = 2;
   localparam int unsigned NV = 26;

   logic clock;
   logic n_reset;
   int   n_checks;
   int   n_errors;

   bcd_digit_entry_if #(.COUNTWIDTH(CW), .MAXDIGITS(MD)) bus ();

`ifdef DIGIT_ECHO_EN
   logic [6:0] echo_seg;
`endif

   bcd_digit_entry #(.COUNTWIDTH(CW), .MAXDIGITS(MD)) dut (
      .clock    (clock),
      .n_reset  (n_reset),
      .bus      (bus)
`ifdef DIGIT_ECHO_EN
      ,
      .echo_seg (echo_seg)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic       valid;
      logic [3:0] d;
      logic       e;
      logic       c;
      logic       ready;   // digit_ready before the edge
      logic       done;    // outputs after the edge
      logic [5:0] value;
      logic       ovf;
      logic       bad;
      logic [1:0] cnt;
   } vec_t;

   vec_t vecs [NV];

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic v, input logic [3:0] d, input logic e, input logic c);
      bus.digit_valid = v;
      bus.digit_in    = d;
      bus.enter       = e;
      bus.clear       = c;
   endtask

   task automatic chk_outs(input string tag, input logic done, input logic [5:0] value,
                           input logic ovf, input logic bad, input logic [1:0] cnt);
      chk({tag, " done"},        int'(bus.done),        int'(done));
      chk({tag, " value"},       int'(bus.value),       int'(value));
      chk({tag, " overflow"},    int'(bus.overflow),    int'(ovf));
      chk({tag, " bad_digit"},   int'(bus.bad_digit),   int'(bad));
      chk({tag, " digit_count"}, int'(bus.digit_count), int'(cnt));
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;

      //            valid d      e     c     ready done value ovf   bad   cnt
      vecs[0]  = '{1'b1, 4'd4,  1'b0, 1'b0, 1'b1, 1'b0, 6'd0,  1'b0, 1'b0, 2'd1};
      vecs[1]  = '{1'b1, 4'd2,  1'b0, 1'b0, 1'b1, 1'b0, 6'd0,  1'b0, 1'b0, 2'd2};
      vecs[2]  = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b1, 6'd42, 1'b0, 1'b0, 2'd0};
      vecs[3]  = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 6'd42, 1'b0, 1'b0, 2'd0};
      vecs[4]  = '{1'b1, 4'd7,  1'b0, 1'b0, 1'b1, 1'b0, 6'd42, 1'b0, 1'b0, 2'd1};
      vecs[5]  = '{1'b1, 4'd5,  1'b0, 1'b0, 1'b1, 1'b0, 6'd42, 1'b0, 1'b0, 2'd2};
      vecs[6]  = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b1, 6'd63, 1'b1, 1'b0, 2'd0};
      vecs[7]  = '{1'b1, 4'd1,  1'b0, 1'b0, 1'b1, 1'b0, 6'd63, 1'b1, 1'b0, 2'd1};
      vecs[8]  = '{1'b1, 4'd2,  1'b0, 1'b0, 1'b1, 1'b0, 6'd63, 1'b1, 1'b0, 2'd2};
      vecs[9]  = '{1'b1, 4'd3,  1'b0, 1'b0, 1'b0, 1'b0, 6'd63, 1'b1, 1'b0, 2'd2};
      vecs[10] = '{1'b1, 4'd3,  1'b1, 1'b0, 1'b0, 1'b1, 6'd12, 1'b0, 1'b0, 2'd0};
      vecs[11] = '{1'b1, 4'd11, 1'b0, 1'b0, 1'b1, 1'b0, 6'd12, 1'b0, 1'b0, 2'd0};
      vecs[12] = '{1'b1, 4'd3,  1'b0, 1'b0, 1'b1, 1'b0, 6'd12, 1'b0, 1'b0, 2'd1};
      vecs[13] = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 1'b1, 6'd3,  1'b0, 1'b1, 2'd0};
      vecs[14] = '{1'b1, 4'd5,  1'b0, 1'b0, 1'b1, 1'b0, 6'd3,  1'b0, 1'b1, 2'd1};
      vecs[15] = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 1'b1, 6'd5,  1'b0, 1'b0, 2'd0};
      vecs[16] = '{1'b1, 4'd6,  1'b0, 1'b0, 1'b1, 1'b0, 6'd5,  1'b0, 1'b0, 2'd1};
      vecs[17] = '{1'b1, 4'd9,  1'b1, 1'b1, 1'b0, 1'b0, 6'd5,  1'b0, 1'b0, 2'd0};
      vecs[18] = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 1'b1, 6'd0,  1'b0, 1'b0, 2'd0};
      vecs[19] = '{1'b1, 4'd3,  1'b0, 1'b0, 1'b1, 1'b0, 6'd0,  1'b0, 1'b0, 2'd1};
      vecs[20] = '{1'b1, 4'd8,  1'b1, 1'b0, 1'b1, 1'b1, 6'd38, 1'b0, 1'b0, 2'd0};
      vecs[21] = '{1'b1, 4'd1,  1'b0, 1'b0, 1'b1, 1'b0, 6'd38, 1'b0, 1'b0, 2'd1};
      vecs[22] = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 1'b1, 6'd1,  1'b0, 1'b0, 2'd0};
      vecs[23] = '{1'b1, 4'd9,  1'b0, 1'b0, 1'b1, 1'b0, 6'd1,  1'b0, 1'b0, 2'd1};
      vecs[24] = '{1'b1, 4'd9,  1'b1, 1'b0, 1'b1, 1'b1, 6'd63, 1'b1, 1'b0, 2'd0};
      vecs[25] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 6'd63, 1'b1, 1'b0, 2'd0};

      // Reset, with a digit presented that must be ignored
      n_reset = 1'b0;
      drive(1'b1, 4'd5, 1'b1, 1'b0);
      repeat (2) @(posedge clock);
      #1;
      chk_outs("reset", 1'b0, 6'd0, 1'b0, 1'b0, 2'd0);
`ifdef DIGIT_ECHO_EN
      chk("reset echo_seg", int'(echo_seg), int'(7'b1000000));
`endif
      drive(1'b0, 4'd0, 1'b0, 1'b0);
      n_reset = 1'b1;
      @(posedge clock);
      #1;
      chk("idle digit_ready", int'(bus.digit_ready), 1);

      // Main vector table
      for (int i = 0; i < int'(NV); i++) begin
         drive(vecs[i].valid, vecs[i].d, vecs[i].e, vecs[i].c);
         #1;
         chk($sformatf("v%0d digit_ready", i), int'(bus.digit_ready), int'(vecs[i].ready));
         @(posedge clock);
         #1;
         chk_outs($sformatf("v%0d", i), vecs[i].done, vecs[i].value,
                  vecs[i].ovf, vecs[i].bad, vecs[i].cnt);
      end

      // Reset mid-entry overrides a pending enter and wipes the committed result
      drive(1'b1, 4'd5, 1'b0, 1'b0);
      @(posedge clock);
      #1;
      chk_outs("mid digit", 1'b0, 6'd63, 1'b1, 1'b0, 2'd1);
      n_reset = 1'b0;
      drive(1'b1, 4'd7, 1'b1, 1'b0);
      @(posedge clock);
      #1;
      chk_outs("mid reset", 1'b0, 6'd0, 1'b0, 1'b0, 2'd0);
      n_reset = 1'b1;
      drive(1'b0, 4'd0, 1'b1, 1'b0);
      @(posedge clock);
      #1;
      chk_outs("post-reset enter", 1'b1, 6'd0, 1'b0, 1'b0, 2'd0);

      // Bad digit while FULL is not consumed and leaves no sticky bad flag
      drive(1'b1, 4'd2, 1'b0, 1'b0);
      @(posedge clock);
      #1;
      drive(1'b1, 4'd1, 1'b0, 1'b0);
      @(posedge clock);
      #1;
      drive(1'b1, 4'd12, 1'b0, 1'b0);
      #1;
      chk("full digit_ready", int'(bus.digit_ready), 0);
      @(posedge clock);
      #1;
      drive(1'b0, 4'd0, 1'b1, 1'b0);
      @(posedge clock);
      #1;
      chk_outs("full bad ignored", 1'b1, 6'd21, 1'b0, 1'b0, 2'd0);
      drive(1'b0, 4'd0, 1'b0, 1'b0);
      @(posedge clock);
      #1;
      chk("done drops", int'(bus.done), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
